alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Parametrised, registered successor to the single-cycle integer ALU.
- Executes the full RV32I ALU op set plus the RV32M multiply/divide ops.
- Sits between decode/operand fetch and writeback, with valid/ready handshakes on both sides.
- Base ops complete in 1 cycle; MUL*/DIV*/REM* use an iterative radix-2 datapath taking DATA_WIDTH cycles.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be >= 8 and a power of 2.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from i_b.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- i_alu_op  in  6  operation code.
- i_a  in  DATA_WIDTH  operand A.
- i_b  in  DATA_WIDTH  operand B.
- i_flush  in  1  synchronous abort of any in-flight op.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_c  out  DATA_WIDTH  result.
- o_illegal  out  1  qualifies o_valid: op code unsupported, o_c=0.

Behaviour:
- Op codes:
  - ADD 011001, SUB 011011, AND 011101, OR 011111, XOR 100001.
  - SLT 100011 (signed), SLTU 100101 (unsigned), SLL 100111, SRL 101001, SRA 101011 (sign-fill).
  - MUL 101101, MULH 101111, MULHSU 110001, MULHU 110011.
  - DIV 110101, DIVU 110111, REM 111001, REMU 111011.
  - Any other code is illegal.
- Shifts use i_b[SHAMT_W-1:0] only.
- MUL returns the low DATA_WIDTH bits of the product. MULH, MULHSU and MULHU return the high bits of the 2*DATA_WIDTH product with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Division semantics:
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
- FSM states are IDLE, BUSY and DONE.
  - o_ready = (state==IDLE).
  - o_valid = (state==DONE).
  - A request is accepted on a rising edge with i_valid && o_ready. Operands and op are captured at that edge and must not be re-sampled later.
- IDLE transitions on accept:
  - Base op, illegal op, or div-by-zero/overflow special case: go to DONE next cycle. Latency 1: o_valid is high in the cycle after accept.
  - Otherwise (mul/div): go to BUSY with the iteration counter = DATA_WIDTH-1. Operands are converted to magnitudes; result sign is recorded.
- BUSY:
  - One radix-2 step per cycle.
  - When the counter reaches 0, apply sign correction, then go to DONE.
  - Total latency from accept to o_valid is DATA_WIDTH+1 cycles (33 for DATA_WIDTH=32).
- DONE:
  - o_c and o_illegal are held stable while o_valid is high.
  - On i_ready go to IDLE. o_ready rises the next cycle; there is no same-cycle back-to-back accept.
- i_flush:
  - Takes priority over all other events.
  - Next state is IDLE; o_valid drops the next cycle; the result is discarded.
  - An accept in the same cycle as i_flush is ignored.
- Reset (asynchronous, any state, including mid-BUSY):
  - state = IDLE, o_valid = 0, o_c = 0, o_illegal = 0, counter = 0.
  - o_ready = 1 after reset deasserts.
- Requests with i_valid while o_ready=0 are not consumed; the upstream stage holds them.
- All arithmetic wraps modulo 2^DATA_WIDTH; there are no overflow flags.

Test Plan:
- Reset mid-BUSY: accept DIV, assert i_rst_n=0 at cycle 10 -> o_valid=0, o_c=0 immediately; after release o_ready=1 and the next ADD 2+3 returns 5 at latency 1.
- Base ops: ADD 0xFFFFFFFF+1 -> 0. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. SRA 0x80000000 by 0x24 -> shift 4 -> 0xF8000000. Each o_valid 1 cycle after accept.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF -> 1. MULH -> 0. MULHU -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF. o_valid exactly 33 cycles after accept; o_ready=0 throughout.
- Divide: DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF, 1-cycle latency. REMU 7/0 -> 7. DIV 0x80000000/-1 -> 0x80000000. REM of the same -> 0.
- Backpressure and illegal op: hold i_ready=0 for 5 cycles after o_valid -> o_c is stable and the second request stalls. Op 000000 -> o_valid with o_illegal=1, o_c=0.
- Flush: assert i_flush at cycle 5 of a MULHU -> o_valid never rises; next cycle o_ready=1; a new AND 0xF0&0x3C returns 0x30.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: registered RV32I/RV32M ALU with valid/ready handshakes on
// both sides. Base ops finish in one cycle. Multiply and divide run an
// iterative radix-2 datapath on operand magnitudes, then sign-correct the result.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [5:0]            i_alu_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_c,
  output logic                  o_illegal
);

  localparam int W = DATA_WIDTH;

  localparam logic [5:0] OP_ADD    = 6'b011001;
  localparam logic [5:0] OP_SUB    = 6'b011011;
  localparam logic [5:0] OP_AND    = 6'b011101;
  localparam logic [5:0] OP_OR     = 6'b011111;
  localparam logic [5:0] OP_XOR    = 6'b100001;
  localparam logic [5:0] OP_SLT    = 6'b100011;
  localparam logic [5:0] OP_SLTU   = 6'b100101;
  localparam logic [5:0] OP_SLL    = 6'b100111;
  localparam logic [5:0] OP_SRL    = 6'b101001;
  localparam logic [5:0] OP_SRA    = 6'b101011;
  localparam logic [5:0] OP_MUL    = 6'b101101;
  localparam logic [5:0] OP_MULH   = 6'b101111;
  localparam logic [5:0] OP_MULHSU = 6'b110001;
  localparam logic [5:0] OP_MULHU  = 6'b110011;
  localparam logic [5:0] OP_DIV    = 6'b110101;
  localparam logic [5:0] OP_DIVU   = 6'b110111;
  localparam logic [5:0] OP_REM    = 6'b111001;
  localparam logic [5:0] OP_REMU   = 6'b111011;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic               negRes_q, negRes_d;
  logic [W-1:0]       opnd_q, opnd_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       result_q, result_d;
  logic               illegal_q, illegal_d;

  logic               isBase;
  logic [W-1:0]       baseRes;
  logic [SHAMT_W-1:0] shamt;

  logic               inMul, inDiv, inRem, inSignA, inSignB;
  logic               aNeg, bNeg, divZero, divOvf;
  logic [W-1:0]       aMag, bMag;

  logic               busyMul, busyRem, busyLow;
  logic [W:0]         mulSum;
  logic [2*W-1:0]     mulNext;
  logic [W:0]         divShift, divDiff;
  logic [2*W-1:0]     divNext;
  logic [2*W-1:0]     stepNext;
  logic [2*W-1:0]     prodFix;
  logic [W-1:0]       divSel;
  logic [W-1:0]       finalRes;

  assign shamt = i_b[SHAMT_W-1:0];

  // Single-cycle result for the RV32I ops; isBase flags codes handled here.
  always_comb begin
    baseRes = '0;
    isBase  = 1'b1;
    case (i_alu_op)
      OP_ADD:  baseRes = i_a + i_b;
      OP_SUB:  baseRes = i_a - i_b;
      OP_AND:  baseRes = i_a & i_b;
      OP_OR:   baseRes = i_a | i_b;
      OP_XOR:  baseRes = i_a ^ i_b;
      OP_SLT:  baseRes = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: baseRes = {{(W-1){1'b0}}, (i_a < i_b)};
      OP_SLL:  baseRes = i_a << shamt;
      OP_SRL:  baseRes = i_a >> shamt;
      OP_SRA:  baseRes = $unsigned($signed(i_a) >>> shamt);
      default: isBase  = 1'b0;
    endcase
  end

  // Classify an incoming mul/div request and take operand magnitudes.
  always_comb begin
    inMul   = (i_alu_op == OP_MUL) || (i_alu_op == OP_MULH) ||
              (i_alu_op == OP_MULHSU) || (i_alu_op == OP_MULHU);
    inDiv   = (i_alu_op == OP_DIV) || (i_alu_op == OP_DIVU) ||
              (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    inRem   = (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    inSignA = (i_alu_op == OP_MULH) || (i_alu_op == OP_MULHSU) ||
              (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    inSignB = (i_alu_op == OP_MULH) || (i_alu_op == OP_DIV) ||
              (i_alu_op == OP_REM);
    aNeg    = inSignA && i_a[W-1];
    bNeg    = inSignB && i_b[W-1];
    aMag    = aNeg ? -i_a : i_a;
    bMag    = bNeg ? -i_b : i_b;
    divZero = inDiv && (i_b == '0);
    divOvf  = ((i_alu_op == OP_DIV) || (i_alu_op == OP_REM)) &&
              (i_a == MIN_VAL) && (i_b == '1);
  end

  // One radix-2 iteration of the shared accumulator plus the sign-corrected
  // result that is committed when the last iteration completes.
  always_comb begin
    busyMul  = (op_q == OP_MUL) || (op_q == OP_MULH) ||
               (op_q == OP_MULHSU) || (op_q == OP_MULHU);
    busyRem  = (op_q == OP_REM) || (op_q == OP_REMU);
    busyLow  = (op_q == OP_MUL);

    mulSum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q & {W{acc_q[0]}}};
    mulNext  = {mulSum, acc_q[W-1:1]};

    divShift = {acc_q[2*W-1:W], acc_q[W-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    divNext  = divDiff[W] ? {divShift[W-1:0], acc_q[W-2:0], 1'b0}
                          : {divDiff[W-1:0],  acc_q[W-2:0], 1'b1};

    stepNext = busyMul ? mulNext : divNext;

    prodFix  = negRes_q ? -stepNext : stepNext;
    divSel   = busyRem ? stepNext[2*W-1:W] : stepNext[W-1:0];
    if (busyMul) begin
      finalRes = busyLow ? prodFix[W-1:0] : prodFix[2*W-1:W];
    end else begin
      finalRes = negRes_q ? -divSel : divSel;
    end
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold in DONE; flush wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    negRes_d  = negRes_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            illegal_d = 1'b0;
            op_d      = i_alu_op;
            if (isBase) begin
              result_d = baseRes;
              state_d  = DONE;
            end else if (divZero) begin
              result_d = inRem ? i_a : '1;
              state_d  = DONE;
            end else if (divOvf) begin
              result_d = inRem ? '0 : MIN_VAL;
              state_d  = DONE;
            end else if (inMul) begin
              opnd_d   = aMag;
              acc_d    = {{W{1'b0}}, bMag};
              negRes_d = aNeg ^ bNeg;
              cnt_d    = SHAMT_W'(W - 1);
              state_d  = BUSY;
            end else if (inDiv) begin
              opnd_d   = bMag;
              acc_d    = {{W{1'b0}}, aMag};
              negRes_d = inRem ? aNeg : (aNeg ^ bNeg);
              cnt_d    = SHAMT_W'(W - 1);
              state_d  = BUSY;
            end else begin
              result_d  = '0;
              illegal_d = 1'b1;
              state_d   = DONE;
            end
          end
        end
        BUSY: begin
          acc_d = stepNext;
          if (cnt_q == '0) begin
            result_d = finalRes;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - SHAMT_W'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset clears everything, even mid-iteration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      negRes_q  <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      negRes_q  <= negRes_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_c       = result_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: randomized and directed stimulus for alu_muldiv_seq,
// compared against an arithmetic reference model of the RV32I/RV32M op set.
module tb_alu_muldiv_seq;

  localparam logic [5:0] OP_ADD    = 6'b011001;
  localparam logic [5:0] OP_SUB    = 6'b011011;
  localparam logic [5:0] OP_AND    = 6'b011101;
  localparam logic [5:0] OP_OR     = 6'b011111;
  localparam logic [5:0] OP_XOR    = 6'b100001;
  localparam logic [5:0] OP_SLT    = 6'b100011;
  localparam logic [5:0] OP_SLTU   = 6'b100101;
  localparam logic [5:0] OP_SLL    = 6'b100111;
  localparam logic [5:0] OP_SRL    = 6'b101001;
  localparam logic [5:0] OP_SRA    = 6'b101011;
  localparam logic [5:0] OP_MUL    = 6'b101101;
  localparam logic [5:0] OP_MULH   = 6'b101111;
  localparam logic [5:0] OP_MULHSU = 6'b110001;
  localparam logic [5:0] OP_MULHU  = 6'b110011;
  localparam logic [5:0] OP_DIV    = 6'b110101;
  localparam logic [5:0] OP_DIVU   = 6'b110111;
  localparam logic [5:0] OP_REM    = 6'b111001;
  localparam logic [5:0] OP_REMU   = 6'b111011;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_alu_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_c;
  logic        o_illegal;

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] baseOps [10] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                               OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
  logic [5:0] mulOps  [4]  = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  logic [5:0] divOps  [4]  = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_alu_op (i_alu_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_c      (o_c),
    .o_illegal(o_illegal)
  );

  // 100 MHz free-running clock.
  always #5 i_clk = ~i_clk;

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: result of an op straight from the arithmetic definition.
  function automatic logic [31:0] refResult(input logic [5:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ua, ub;
    int          ia, ib;
    int unsigned sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    sh = int'(b & 32'h1F);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLT:    return (ia < ib) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:    return a << sh;
      OP_SRL:    return a >> sh;
      OP_SRA:    return $unsigned(ia >>> sh);
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic bit isMulDiv(input logic [5:0] op);
    foreach (mulOps[i]) if (mulOps[i] == op) return 1'b1;
    foreach (divOps[i]) if (divOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit isLegal(input logic [5:0] op);
    foreach (baseOps[i]) if (baseOps[i] == op) return 1'b1;
    return isMulDiv(op);
  endfunction

  // Iterative ops take 33 cycles unless a divide short-circuits.
  function automatic int expLatency(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    bit isDivOp;
    isDivOp = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    if (!isMulDiv(op)) return 1;
    if (isDivOp && b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Operand mix biased toward corner values.
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Waits (bounded) until the block can take a request.
  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  // Presents one request for exactly one accepting edge.
  task automatic issueOnly(input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    i_alu_op = op;
    i_a      = a;
    i_b      = b;
    i_valid  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_a      = 32'($urandom);
    i_b      = 32'($urandom);
  endtask

  // Counts cycles from accept until o_valid; notes any o_ready while waiting.
  task automatic waitValid(output int lat, output bit readySeen);
    lat       = 1;
    readySeen = 1'b0;
    while (!o_valid && lat < 100) begin
      if (o_ready) readySeen = 1'b1;
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  // Full transaction: issue, wait for result, capture it, then drain.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output logic ill, output int lat,
                               output bit readySeen);
    bit ok;
    waitReady(ok);
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: o_ready=%b required 1", o_ready);
    end
    issueOnly(op, a, b);
    waitValid(lat, readySeen);
    res = o_c;
    ill = o_illegal;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  // Reset values, then an asynchronous reset in the middle of a divide.
  task automatic test_reset();
    logic [31:0] res;
    logic        ill;
    int          lat;
    bit          rs;
    vectors++;
    if (o_valid !== 1'b0 || o_c !== 32'd0 || o_illegal !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_state: valid=%b c=%h illegal=%b ready=%b required 0/0/0/1",
               o_valid, o_c, o_illegal, o_ready);
    end
    applyStimulus(OP_ADD, 32'd5, 32'd6, res, ill, lat, rs);
    vectors++;
    if (res !== 32'd11) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_add: got %h required %h", res, 32'd11);
    end
    issueOnly(OP_DIV, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge i_clk);
      #1;
    end
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if (o_valid !== 1'b0 || o_c !== 32'd0 || o_illegal !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_busy: valid=%b c=%h illegal=%b required 0/0/0",
               o_valid, o_c, o_illegal);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: ready=%b valid=%b required 1/0", o_ready, o_valid);
    end
    applyStimulus(OP_ADD, 32'd2, 32'd3, res, ill, lat, rs);
    vectors++;
    if (res !== 32'd5 || lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL add_after_reset: got %h lat %0d required 5 lat 1", res, lat);
    end
  endtask

  // Directed corner cases and random base ops, all with latency 1.
  task automatic test_base_ops();
    logic [5:0]  ops [4] = '{OP_ADD, OP_SLT, OP_SLTU, OP_SRA};
    logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd1, 32'd1, 32'd1, 32'h24};
    logic [31:0] ex  [4] = '{32'd0, 32'd1, 32'd0, 32'hF800_0000};
    logic [31:0] res, a, b, exp;
    logic [5:0]  op;
    logic        ill;
    int          lat;
    bit          rs;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], as[i], bs[i], res, ill, lat, rs);
      vectors++;
      if (res !== ex[i] || lat !== 1 || ill !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL base_fixed[%0d] op %b: got %h lat %0d ill %b required %h lat 1 ill 0",
                 i, ops[i], res, lat, ill, ex[i]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      op  = baseOps[$urandom_range(0, 9)];
      a   = pickOperand();
      b   = pickOperand();
      exp = refResult(op, a, b);
      applyStimulus(op, a, b, res, ill, lat, rs);
      vectors++;
      if (res !== exp || lat !== 1 || ill !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL base_rand op %b a %h b %h: got %h lat %0d required %h lat 1",
                 op, a, b, res, lat, exp);
      end
    end
  endtask

  // Multiply variants: result, 33-cycle latency, o_ready low while busy.
  task automatic test_multiply();
    logic [5:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] ex  [4] = '{32'd1, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res, a, b, exp;
    logic [5:0]  op;
    logic        ill;
    int          lat;
    bit          rs;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], 32'hFFFF_FFFF, bs[i], res, ill, lat, rs);
      vectors++;
      if (res !== ex[i] || lat !== 33 || rs !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mul_fixed[%0d]: got %h lat %0d readySeen %b required %h lat 33 readySeen 0",
                 i, res, lat, rs, ex[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      op  = mulOps[$urandom_range(0, 3)];
      a   = pickOperand();
      b   = pickOperand();
      exp = refResult(op, a, b);
      applyStimulus(op, a, b, res, ill, lat, rs);
      vectors++;
      if (res !== exp || lat !== 33 || rs !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL mul_rand op %b a %h b %h: got %h lat %0d required %h lat 33",
                 op, a, b, res, lat, exp);
      end
    end
  endtask

  // Divide/remainder incl. divide-by-zero and MIN/-1 short cuts.
  task automatic test_divide();
    logic [5:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                             32'h8000_0000, 32'd0};
    int          el  [6] = '{33, 33, 1, 1, 1, 1};
    logic [31:0] res, a, b, exp;
    logic [5:0]  op;
    logic        ill;
    int          lat, expLat;
    bit          rs;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ops[i], as[i], bs[i], res, ill, lat, rs);
      vectors++;
      if (res !== ex[i] || lat !== el[i]) begin
        miscompares++;
        $display("[TB] FAIL div_fixed[%0d]: got %h lat %0d required %h lat %0d",
                 i, res, lat, ex[i], el[i]);
      end
    end
    for (int i = 0; i < 14; i++) begin
      op     = divOps[$urandom_range(0, 3)];
      a      = pickOperand();
      b      = pickOperand();
      exp    = refResult(op, a, b);
      expLat = expLatency(op, a, b);
      applyStimulus(op, a, b, res, ill, lat, rs);
      vectors++;
      if (res !== exp || lat !== expLat) begin
        miscompares++;
        $display("[TB] FAIL div_rand op %b a %h b %h: got %h lat %0d required %h lat %0d",
                 op, a, b, res, lat, exp, expLat);
      end
    end
  endtask

  // Result held under backpressure while a second request waits upstream.
  task automatic test_backpressure();
    logic [31:0] a1, b1, exp1, a2, b2, exp2;
    int          lat;
    bit          rs, ok;
    a1   = 32'($urandom);
    b1   = 32'($urandom);
    exp1 = refResult(OP_MUL, a1, b1);
    a2   = 32'($urandom);
    b2   = 32'($urandom);
    exp2 = refResult(OP_XOR, a2, b2);
    waitReady(ok);
    issueOnly(OP_MUL, a1, b1);
    waitValid(lat, rs);
    i_alu_op = OP_XOR;
    i_a      = a2;
    i_b      = b2;
    i_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_c !== exp1 || o_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL backpressure_hold[%0d]: valid=%b c=%h ready=%b required 1/%h/0",
                 i, o_valid, o_c, o_ready, exp1);
      end
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_release: ready=%b valid=%b required 1/0", o_ready, o_valid);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    vectors++;
    if (o_valid !== 1'b1 || o_c !== exp2) begin
      miscompares++;
      $display("[TB] FAIL stalled_request: valid=%b c=%h required 1/%h", o_valid, o_c, exp2);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  // Unsupported codes complete in one cycle with o_illegal and a zero result.
  task automatic test_illegal();
    logic [31:0] res;
    logic [5:0]  op;
    logic        ill;
    int          lat;
    bit          rs;
    for (int i = 0; i < 6; i++) begin
      op = 6'd0;
      if (i > 0) begin
        for (int k = 0; k < 64; k++) begin
          op = 6'($urandom_range(0, 63));
          if (!isLegal(op)) break;
        end
      end
      applyStimulus(op, 32'($urandom), 32'($urandom), res, ill, lat, rs);
      vectors++;
      if (ill !== 1'b1 || res !== 32'd0 || lat !== 1) begin
        miscompares++;
        $display("[TB] FAIL illegal op %b: ill %b c %h lat %0d required 1/0/1", op, ill, res, lat);
      end
    end
  endtask

  // Flush aborts an in-flight multiply and suppresses a same-cycle accept.
  task automatic test_flush();
    logic [31:0] res;
    logic        ill;
    int          lat;
    bit          rs, ok, sawValid;
    waitReady(ok);
    issueOnly(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (4) begin
      @(posedge i_clk);
      #1;
    end
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_busy: ready=%b valid=%b required 1/0", o_ready, o_valid);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) sawValid = 1'b1;
      @(posedge i_clk);
      #1;
    end
    vectors++;
    if (sawValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_no_result: saw o_valid=%b required 0", sawValid);
    end
    i_alu_op = OP_ADD;
    i_a      = 32'd1;
    i_b      = 32'd1;
    i_valid  = 1'b1;
    i_flush  = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_flush  = 1'b0;
    vectors++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_accept: ready=%b valid=%b required 1/0", o_ready, o_valid);
    end
    applyStimulus(OP_AND, 32'hF0, 32'h3C, res, ill, lat, rs);
    vectors++;
    if (res !== 32'h30 || lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL and_after_flush: got %h lat %0d required 30 lat 1", res, lat);
    end
  endtask

  // Test sequence.
  initial begin
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_flush  = 1'b0;
    i_ready  = 1'b0;
    i_alu_op = 6'd0;
    i_a      = 32'd0;
    i_b      = 32'd0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    test_reset();
    test_base_ops();
    test_multiply();
    test_divide();
    test_backpressure();
    test_illegal();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
